// File: rtl/transposer_pkg.sv
// transposer_pkg: shared element/row/block types for the ping-pong transposer
package transposer_pkg;
  localparam int ELEM_W = 16;
  localparam int N = 4;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [N-1:0] row_t;
  typedef row_t [N-1:0] block_t;
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: NxN element registers, row-write port and combinational column-read port
module transpose_bank
  import transposer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] row,
  input  row_t             wdata,
  input  logic [IDX_W-1:0] col,
  output row_t             rdata
);
  block_t mem;
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '0;
    else if (we) mem[row] <= wdata;
  always_comb begin
    rdata = '0;
    for (int r = 0; r < N; r++) rdata[r] = mem[r][col];
  end
endmodule

// File: rtl/pingpong_transposer.sv
// pingpong_transposer: double-buffered 4x4 row-in/column-out transposer.
// TRANSPOSER_OVF_CHECK_EN enables in_ready backpressure and the sticky overflow flag.
module pingpong_transposer
  import transposer_pkg::*;
#(
  parameter int ELEM_W = transposer_pkg::ELEM_W,
  parameter int N = transposer_pkg::N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*ELEM_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*ELEM_W-1:0] data_out,
  output logic              wr_bank,
  output logic              overflow
);
  logic [1:0] full, full_nxt;
  logic rd_bank, wr_en, rd_en;
  logic [IDX_W-1:0] wr_row, rd_col;
  row_t col0, col1;
`ifdef TRANSPOSER_OVF_CHECK_EN
  assign in_ready = !full[wr_bank];
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (flush) overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
`else
  assign in_ready = 1'b1;
  assign overflow = 1'b0;
`endif
  assign wr_en = in_valid && in_ready && !flush;
  assign rd_en = out_valid && out_ready && !flush;
  assign out_valid = full[rd_bank];
  assign data_out = rd_bank ? col1 : col0;
  // drain clears before fill sets, so an overwrite landing on the draining bank keeps it full
  always_comb begin
    full_nxt = full;
    if (rd_en && rd_col == LAST) full_nxt[rd_bank] = 1'b0;
    if (wr_en && wr_row == LAST) full_nxt[wr_bank] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) wr_row <= wr_row + 1'b1;
      if (wr_en && wr_row == LAST) wr_bank <= !wr_bank;
      if (rd_en) rd_col <= rd_col + 1'b1;
      if (rd_en && rd_col == LAST) rd_bank <= !rd_bank;
    end
  transpose_bank u_bank0 (
    .clk(clk), .rst(rst), .we(wr_en && !wr_bank), .row(wr_row), .wdata(data_in),
    .col(rd_col), .rdata(col0)
  );
  transpose_bank u_bank1 (
    .clk(clk), .rst(rst), .we(wr_en && wr_bank), .row(wr_row), .wdata(data_in),
    .col(rd_col), .rdata(col1)
  );
endmodule

// File: tb/tb_pingpong_transposer.sv
// tb_pingpong_transposer: directed stimulus with a column scoreboard checked by a monitor
module tb_pingpong_transposer;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, wr_bank, overflow;
  logic [63:0] data_in = '0, data_out;
  logic [63:0] exp_q[$];
  int checks = 0, failures = 0;

  pingpong_transposer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .wr_bank(wr_bank), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] row_w(int base, int r);
    logic [63:0] w;
    for (int c = 0; c < 4; c++) w[16*c +: 16] = 16'(base + 16*r + c);
    return w;
  endfunction

  function automatic logic [63:0] col_w(int base, int c);
    logic [63:0] w;
    for (int r = 0; r < 4; r++) w[16*r +: 16] = 16'(base + 16*r + c);
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_block(int base);
    for (int c = 0; c < 4; c++) exp_q.push_back(col_w(base, c));
  endtask

  task automatic offer(logic [63:0] w, logic exp_rdy);
    in_valid = 1'b1;
    data_in = w;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic write_block(int base, logic exp_rdy);
    for (int r = 0; r < 4; r++) offer(row_w(base, r), exp_rdy);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL column_unexpected got=%h expected=none", data_out);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL column got=%h expected=%h", data_out, e);
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_wr_bank", 64'(wr_bank), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    // single block: latency and hand-computed columns
    out_ready = 1'b1;
    chk("row0_pattern", row_w(0, 0), 64'h0003_0002_0001_0000);
    write_block(0, 1'b1);
    push_block(0);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_col0", data_out, 64'h0030_0020_0010_0000);
    chk("col3_pattern", col_w(0, 3), 64'h0033_0023_0013_0003);
    drain();
    // three back-to-back blocks
    do_flush();
    chk("stream_wr_bank0", 64'(wr_bank), 64'd0);
    write_block('h100, 1'b1);
    push_block('h100);
    chk("stream_wr_bank1", 64'(wr_bank), 64'd1);
    write_block('h200, 1'b1);
    push_block('h200);
    chk("stream_wr_bank2", 64'(wr_bank), 64'd0);
    write_block('h300, 1'b1);
    push_block('h300);
    chk("stream_wr_bank3", 64'(wr_bank), 64'd1);
    repeat (4) @(posedge clk);
    #1 chk("stream_contiguous", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
`ifdef TRANSPOSER_OVF_CHECK_EN
    do_flush();
    write_block('h180, 1'b1);
    write_block('h280, 1'b1);
    write_block('h380, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_out_valid", 64'(out_valid), 64'd1);
    push_block('h180);
    push_block('h280);
    out_ready = 1'b1;
    drain();
`endif
    // flush mid-block
    out_ready = 1'b1;
    offer(row_w('h400, 0), 1'b1);
    offer(row_w('h400, 1), 1'b1);
    do_flush();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_overflow", 64'(overflow), 64'd0);
    chk("flush_wr_bank", 64'(wr_bank), 64'd0);
    write_block('h500, 1'b1);
    push_block('h500);
    drain();
    // reset mid-read at column 2
    out_ready = 1'b0;
    write_block('h600, 1'b1);
    push_block('h600);
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_data_out", data_out, 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_wr_bank", 64'(wr_bank), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst2_no_cols", 64'(out_valid), 64'd0);
    write_block('h700, 1'b1);
    push_block('h700);
    drain();
`ifndef TRANSPOSER_OVF_CHECK_EN
    // overwrite mode: third block lands in bank 0 over the unread first block
    out_ready = 1'b0;
    do_flush();
    write_block('h800, 1'b1);
    write_block('h900, 1'b1);
    write_block('hA00, 1'b1);
    chk("novf_overflow", 64'(overflow), 64'd0);
    push_block('hA00);
    push_block('h900);
    out_ready = 1'b1;
    drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
